alu_issue: RTL and testbench
============================

# alu_issue

ID/EX issue stage for the pipelined DLX core: accepts decoded-stage instructions over a valid/ready handshake and produces the 4-bit ALU opcode and both ALU operands. It performs operand selection and result forwarding, detects load-use and RAW hazards, and holds everything in the ID/EX pipeline register that drives the EX-stage ALU. It is the initiator side of the ALU opcode/operand interface.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds an instruction
- id_ready  out  1  issue stage accepts this cycle
- id_instr  in  32  raw DLX instruction
- id_rs1_data, id_rs2_data  in  32  register-file read data
- flush  in  1  taken branch; kill ID/EX contents
- ex_ready  in  1  EX stage consumes ID/EX this cycle
- exmem_wr_en, memwb_wr_en  in  1  downstream write-back pending
- exmem_rd, memwb_rd  in  5  downstream destination
- exmem_data, memwb_data  in  32  downstream result
- alu_valid  out  1  ID/EX holds a live instruction
- alu_opcode  out  4  ALU operation code
- alu_in1, alu_in2  out  32  ALU operands
- alu_rd  out  5  destination register
- alu_wr_en, alu_mem_rd, alu_mem_wr  out  1  write-back / load / store
- alu_store_data  out  32  store data (forwarded rs2)
- illegal  out  1  one-cycle pulse on unsupported instruction

## Operation
- Decode, R-type (op 0x00) by func: ADD 0x20->0010, SUB 0x22->0110, AND 0x24->0000, OR 0x25->0001, SLT 0x2A->0111; rd=instr[15:11], in2=rs2.
- I-type: ADDI 0x08->0010, SLTI 0x0A->0111 (sign-extend imm16); ANDI 0x0C->0000, ORI 0x0D->0001 (zero-extend); LW 0x23 / SW 0x2B ->0010, sign-extended imm, rd=instr[20:16]; BEQZ 0x04->0110 with in2=0, alu_wr_en=0.
- Any other op/func: consumed, ID/EX becomes bubble, illegal=1 for that cycle.
- Sources: rs1=instr[25:21], rs2=instr[20:16]. Index 0 always reads 0, never forwarded, never hazards.
- Forward priority per source: EX/MEM (exmem_wr_en & rd match) > MEM/WB > register file.
- Load-use: ID/EX holds valid LW whose alu_rd matches a used source -> stall one cycle; ID/EX becomes bubble when EX consumes.
- Register enable: load = ~alu_valid | ex_ready. id_ready = load & ~hazard. Transfer on id_valid & id_ready.
- If load and no transfer: alu_valid<=0 (bubble). If ~load: hold all outputs.
- flush: alu_valid<=0 next edge; id_ready=1; ID instruction discarded, illegal suppressed. flush beats stall and hold.

## Timing
- Latency 1: instruction accepted at edge N appears on alu_* after edge N.
- Reset: alu_valid, alu_wr_en, alu_mem_rd, alu_mem_wr, illegal = 0; alu_opcode=4'b0000; alu_in1, alu_in2, alu_store_data=0; alu_rd=0. id_ready=0 while rst high.
- Forward/hazard comparisons are combinational against same-cycle exmem/memwb inputs.
- Bubbles carry alu_wr_en=alu_mem_rd=alu_mem_wr=0; other fields don't-care but held.
- Reset mid-stall: stall state cleared; first post-reset instruction issues without bubble.

## Configuration
- ALU_ISSUE_FORWARD_EN defined: forwarding and single-bubble load-use as above.
- Undefined: no forwarding; ID stalls (id_ready=0) while any used source matches a valid write-enabled destination in ID/EX, EX/MEM or MEM/WB; operands come only from the register file.

## Test plan
- Reset then ADD r3,r1,r2 with rs1=5, rs2=7 -> next cycle alu_valid=1, opcode 0010, in1=5, in2=7, rd=3.
- SUB r4,r3,r1 with exmem_rd=3, exmem_data=0x10, memwb_rd=3, memwb_data=0x20 -> in1=0x10 (EX/MEM wins).
- LW r5,4(r1) then ADD r6,r5,r2 -> one bubble (alu_valid=0), id_ready low one cycle, ADD issues next.
- ex_ready=0 for 3 cycles with valid ID/EX -> all alu_* outputs stable, id_ready=0.
- flush during valid ORI -> next cycle alu_valid=0, no illegal; op 0x3F -> illegal pulse, bubble.
- Without ALU_ISSUE_FORWARD_EN: ADD r3 then AND r7,r3,r3 -> id_ready low until r3 leaves MEM/WB.

Source files
------------

// File: rtl/alu_issue.sv
// ID/EX issue stage for the DLX pipeline: decodes, selects/forwards operands, detects hazards
// and holds the ID/EX register. Define ALU_ISSUE_FORWARD_EN for forwarding with single-bubble load-use.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic        flush,
    input  logic        ex_ready,
    input  logic        exmem_wr_en,
    input  logic        memwb_wr_en,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_data,
    input  logic [31:0] memwb_data,
    output logic        alu_valid,
    output logic [3:0]  alu_opcode,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_rd,
    output logic        alu_wr_en,
    output logic        alu_mem_rd,
    output logic        alu_mem_wr,
    output logic [31:0] alu_store_data,
    output logic        illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        SEL_RS2,
        SEL_SIMM,
        SEL_ZIMM,
        SEL_ZERO
    } in2_sel_t;

    logic [5:0]  w_op;
    logic [5:0]  w_func;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [15:0] w_imm;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;

    assign w_op   = id_instr[31:26];
    assign w_func = id_instr[5:0];
    assign w_rs1  = id_instr[25:21];
    assign w_rs2  = id_instr[20:16];
    assign w_imm  = id_instr[15:0];
    assign w_simm = {{16{w_imm[15]}}, w_imm};
    assign w_zimm = {16'h0000, w_imm};

    logic     w_decOk;
    logic [3:0] w_aluOp;
    logic     w_useRs1;
    logic     w_useRs2;
    logic [4:0] w_rd;
    logic     w_wrEn;
    logic     w_memRd;
    logic     w_memWr;
    in2_sel_t w_in2Sel;

    always_comb begin
        w_decOk  = 1'b0;
        w_aluOp  = ALU_AND;
        w_useRs1 = 1'b0;
        w_useRs2 = 1'b0;
        w_rd     = id_instr[20:16];
        w_wrEn   = 1'b0;
        w_memRd  = 1'b0;
        w_memWr  = 1'b0;
        w_in2Sel = SEL_RS2;
        case (w_op)
            OP_RTYPE: begin
                w_rd     = id_instr[15:11];
                w_useRs1 = 1'b1;
                w_useRs2 = 1'b1;
                w_wrEn   = 1'b1;
                w_decOk  = 1'b1;
                case (w_func)
                    FN_ADD:  w_aluOp = ALU_ADD;
                    FN_SUB:  w_aluOp = ALU_SUB;
                    FN_AND:  w_aluOp = ALU_AND;
                    FN_OR:   w_aluOp = ALU_OR;
                    FN_SLT:  w_aluOp = ALU_SLT;
                    default: w_decOk = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_aluOp  = ALU_ADD;
                w_in2Sel = SEL_SIMM;
                w_useRs1 = 1'b1;
                w_wrEn   = 1'b1;
                w_decOk  = 1'b1;
            end
            OP_SLTI: begin
                w_aluOp  = ALU_SLT;
                w_in2Sel = SEL_SIMM;
                w_useRs1 = 1'b1;
                w_wrEn   = 1'b1;
                w_decOk  = 1'b1;
            end
            OP_ANDI: begin
                w_aluOp  = ALU_AND;
                w_in2Sel = SEL_ZIMM;
                w_useRs1 = 1'b1;
                w_wrEn   = 1'b1;
                w_decOk  = 1'b1;
            end
            OP_ORI: begin
                w_aluOp  = ALU_OR;
                w_in2Sel = SEL_ZIMM;
                w_useRs1 = 1'b1;
                w_wrEn   = 1'b1;
                w_decOk  = 1'b1;
            end
            OP_LW: begin
                w_aluOp  = ALU_ADD;
                w_in2Sel = SEL_SIMM;
                w_useRs1 = 1'b1;
                w_wrEn   = 1'b1;
                w_memRd  = 1'b1;
                w_decOk  = 1'b1;
            end
            OP_SW: begin
                w_aluOp  = ALU_ADD;
                w_in2Sel = SEL_SIMM;
                w_useRs1 = 1'b1;
                w_useRs2 = 1'b1;
                w_memWr  = 1'b1;
                w_decOk  = 1'b1;
            end
            OP_BEQZ: begin
                w_aluOp  = ALU_SUB;
                w_in2Sel = SEL_ZERO;
                w_useRs1 = 1'b1;
                w_decOk  = 1'b1;
            end
            default: ;
        endcase
    end

    // Pipeline register state
    logic        r_valid;
    logic [3:0]  r_opcode;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [4:0]  r_rd;
    logic        r_wrEn;
    logic        r_memRd;
    logic        r_memWr;
    logic [31:0] r_storeData;
    logic        r_illegal;

    logic w_src1;
    logic w_src2;
    assign w_src1 = id_valid & w_decOk & w_useRs1 & (w_rs1 != 5'd0);
    assign w_src2 = id_valid & w_decOk & w_useRs2 & (w_rs2 != 5'd0);

    logic [31:0] w_rs1Val;
    logic [31:0] w_rs2Val;
    logic        w_hazard;
    logic        w_unused;

`ifdef ALU_ISSUE_FORWARD_EN
    // EX/MEM result is newer than MEM/WB, so it wins when both target the same register.
    function automatic logic [31:0] fwdVal(
        input logic [4:0]  idx,
        input logic [31:0] rfData,
        input logic        exEn,
        input logic [4:0]  exRd,
        input logic [31:0] exData,
        input logic        wbEn,
        input logic [4:0]  wbRd,
        input logic [31:0] wbData
    );
        logic [31:0] v;
        if (idx == 5'd0)
            v = 32'h0;
        else if (exEn && (exRd == idx))
            v = exData;
        else if (wbEn && (wbRd == idx))
            v = wbData;
        else
            v = rfData;
        return v;
    endfunction

    assign w_rs1Val = fwdVal(w_rs1, id_rs1_data, exmem_wr_en, exmem_rd, exmem_data,
                             memwb_wr_en, memwb_rd, memwb_data);
    assign w_rs2Val = fwdVal(w_rs2, id_rs2_data, exmem_wr_en, exmem_rd, exmem_data,
                             memwb_wr_en, memwb_rd, memwb_data);

    // Only a load sitting in ID/EX cannot be forwarded in time.
    assign w_hazard = r_valid & r_memRd &
                      ((w_src1 & (r_rd == w_rs1)) | (w_src2 & (r_rd == w_rs2)));
    assign w_unused = &{1'b0, id_instr[10:6]};
`else
    logic w_rs1Busy;
    logic w_rs2Busy;

    assign w_rs1Val = (w_rs1 == 5'd0) ? 32'h0 : id_rs1_data;
    assign w_rs2Val = (w_rs2 == 5'd0) ? 32'h0 : id_rs2_data;

    // Without forwarding, any in-flight writer of a source blocks issue until it retires.
    assign w_rs1Busy = w_src1 & ((r_valid & r_wrEn & (r_rd == w_rs1)) |
                                 (exmem_wr_en & (exmem_rd == w_rs1)) |
                                 (memwb_wr_en & (memwb_rd == w_rs1)));
    assign w_rs2Busy = w_src2 & ((r_valid & r_wrEn & (r_rd == w_rs2)) |
                                 (exmem_wr_en & (exmem_rd == w_rs2)) |
                                 (memwb_wr_en & (memwb_rd == w_rs2)));
    assign w_hazard  = w_rs1Busy | w_rs2Busy;
    assign w_unused  = &{1'b0, id_instr[10:6], exmem_data, memwb_data};
`endif

    logic [31:0] w_in2;
    always_comb begin
        w_in2 = w_rs2Val;
        case (w_in2Sel)
            SEL_RS2:  w_in2 = w_rs2Val;
            SEL_SIMM: w_in2 = w_simm;
            SEL_ZIMM: w_in2 = w_zimm;
            SEL_ZERO: w_in2 = 32'h0;
            default:  w_in2 = w_rs2Val;
        endcase
    end

    logic w_load;
    logic w_transfer;
    assign w_load     = ~r_valid | ex_ready;
    assign id_ready   = ~rst & (flush | (w_load & ~w_hazard));
    assign w_transfer = id_valid & id_ready;

    // Flush overrides both stall and hold; bubbles keep data fields but drop all side effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_opcode    <= 4'b0000;
            r_in1       <= 32'h0;
            r_in2       <= 32'h0;
            r_rd        <= 5'd0;
            r_wrEn      <= 1'b0;
            r_memRd     <= 1'b0;
            r_memWr     <= 1'b0;
            r_storeData <= 32'h0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            if (flush) begin
                r_valid <= 1'b0;
                r_wrEn  <= 1'b0;
                r_memRd <= 1'b0;
                r_memWr <= 1'b0;
            end else if (w_load) begin
                if (w_transfer && w_decOk) begin
                    r_valid     <= 1'b1;
                    r_opcode    <= w_aluOp;
                    r_in1       <= w_rs1Val;
                    r_in2       <= w_in2;
                    r_rd        <= w_rd;
                    r_wrEn      <= w_wrEn;
                    r_memRd     <= w_memRd;
                    r_memWr     <= w_memWr;
                    r_storeData <= w_rs2Val;
                end else begin
                    r_valid   <= 1'b0;
                    r_wrEn    <= 1'b0;
                    r_memRd   <= 1'b0;
                    r_memWr   <= 1'b0;
                    r_illegal <= w_transfer;
                end
            end
        end
    end

    assign alu_valid      = r_valid;
    assign alu_opcode     = r_opcode;
    assign alu_in1        = r_in1;
    assign alu_in2        = r_in2;
    assign alu_rd         = r_rd;
    assign alu_wr_en      = r_wrEn;
    assign alu_mem_rd     = r_memRd;
    assign alu_mem_wr     = r_memWr;
    assign alu_store_data = r_storeData;
    assign illegal        = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue; expectations adapt to ALU_ISSUE_FORWARD_EN.
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        flush;
    logic        ex_ready;
    logic        exmem_wr_en;
    logic        memwb_wr_en;
    logic [4:0]  exmem_rd;
    logic [4:0]  memwb_rd;
    logic [31:0] exmem_data;
    logic [31:0] memwb_data;
    logic        alu_valid;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  alu_rd;
    logic        alu_wr_en;
    logic        alu_mem_rd;
    logic        alu_mem_wr;
    logic [31:0] alu_store_data;
    logic        illegal;

    int nChecks = 0;
    int nPass   = 0;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .flush(flush), .ex_ready(ex_ready),
        .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .alu_valid(alu_valid), .alu_opcode(alu_opcode),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_rd(alu_rd),
        .alu_wr_en(alu_wr_en), .alu_mem_rd(alu_mem_rd), .alu_mem_wr(alu_mem_wr),
        .alu_store_data(alu_store_data), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs1, rs2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs1, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;
        exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_data = 32'h0; memwb_data = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        id_instr = 32'h0; id_rs1_data = 32'h0; id_rs2_data = 32'h0;
        rst = 1'b1;
        tick();
        id_valid = 1'b1;
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        #1;
        nChecks++; if (id_ready !== 1'b0) $display("[TB] FAIL reset_id_ready: got %b expected 0", id_ready); else nPass++;
        tick();
        id_valid = 1'b0;
        rst = 1'b0;
        #1;
        nChecks++; if (alu_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", alu_valid); else nPass++;
        nChecks++;
        if ({alu_opcode, alu_in1, alu_in2, alu_rd, alu_store_data} !== 105'h0)
            $display("[TB] FAIL reset_fields: got %h %h %h %h %h expected all 0", alu_opcode, alu_in1, alu_in2, alu_rd, alu_store_data);
        else nPass++;
        nChecks++;
        if ({alu_wr_en, alu_mem_rd, alu_mem_wr, illegal} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {alu_wr_en, alu_mem_rd, alu_mem_wr, illegal});
        else nPass++;
    endtask

    task automatic test_add();
        idle();
        id_valid = 1'b1;
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        id_rs1_data = 32'd5; id_rs2_data = 32'd7;
        #1;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL add_id_ready: got %b expected 1", id_ready); else nPass++;
        tick();
        id_valid = 1'b0;
        nChecks++;
        if ({alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd, alu_wr_en} !== {1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b1})
            $display("[TB] FAIL add_issue: got v=%b op=%b in1=%h in2=%h rd=%0d wr=%b expected v=1 op=0010 in1=5 in2=7 rd=3 wr=1",
                     alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd, alu_wr_en);
        else nPass++;
        tick();
        nChecks++; if (alu_valid !== 1'b0) $display("[TB] FAIL add_drain: got %b expected 0", alu_valid); else nPass++;
    endtask

    task automatic test_forward();
        idle();
        id_valid = 1'b1;
        id_instr = rtype(5'd3, 5'd1, 5'd4, 6'h22);
        id_rs1_data = 32'h99; id_rs2_data = 32'h3;
        exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_data = 32'h10;
        memwb_wr_en = 1'b1; memwb_rd = 5'd3; memwb_data = 32'h20;
        #1;
`ifdef ALU_ISSUE_FORWARD_EN
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL fwd_id_ready: got %b expected 1", id_ready); else nPass++;
        tick();
        id_valid = 1'b0;
        nChecks++;
        if ({alu_valid, alu_opcode, alu_in1, alu_in2} !== {1'b1, 4'b0110, 32'h10, 32'h3})
            $display("[TB] FAIL fwd_exmem_wins: got v=%b op=%b in1=%h in2=%h expected v=1 op=0110 in1=10 in2=3",
                     alu_valid, alu_opcode, alu_in1, alu_in2);
        else nPass++;
        memwb_rd = 5'd1; memwb_data = 32'h44; exmem_rd = 5'd9;
        id_valid = 1'b1;
        #1;
        tick();
        id_valid = 1'b0;
        nChecks++;
        if ({alu_in1, alu_in2} !== {32'h99, 32'h44})
            $display("[TB] FAIL fwd_memwb: got in1=%h in2=%h expected in1=99 in2=44", alu_in1, alu_in2);
        else nPass++;
`else
        nChecks++; if (id_ready !== 1'b0) $display("[TB] FAIL nofwd_stall: got %b expected 0", id_ready); else nPass++;
        tick();
        nChecks++; if (alu_valid !== 1'b0) $display("[TB] FAIL nofwd_bubble: got %b expected 0", alu_valid); else nPass++;
        exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;
        #1;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL nofwd_release: got %b expected 1", id_ready); else nPass++;
        tick();
        id_valid = 1'b0;
        nChecks++;
        if ({alu_valid, alu_opcode, alu_in1, alu_in2} !== {1'b1, 4'b0110, 32'h99, 32'h3})
            $display("[TB] FAIL nofwd_rf_operands: got v=%b op=%b in1=%h in2=%h expected v=1 op=0110 in1=99 in2=3",
                     alu_valid, alu_opcode, alu_in1, alu_in2);
        else nPass++;
`endif
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr [13];
        logic [3:0]  eOp   [13];
        logic [31:0] eIn1  [13];
        logic [31:0] eIn2  [13];
        logic [4:0]  eRd   [13];
        logic [2:0]  eFlg  [13];
        logic [31:0] eSt   [13];
        instr[0]  = rtype(5'd1, 5'd2, 5'd8, 6'h20);         eOp[0]  = 4'b0010; eIn2[0]  = 32'hA5;       eRd[0]  = 5'd8;  eFlg[0]  = 3'b100;
        instr[1]  = rtype(5'd1, 5'd2, 5'd9, 6'h22);         eOp[1]  = 4'b0110; eIn2[1]  = 32'hA5;       eRd[1]  = 5'd9;  eFlg[1]  = 3'b100;
        instr[2]  = rtype(5'd1, 5'd2, 5'd10, 6'h24);        eOp[2]  = 4'b0000; eIn2[2]  = 32'hA5;       eRd[2]  = 5'd10; eFlg[2]  = 3'b100;
        instr[3]  = rtype(5'd1, 5'd2, 5'd11, 6'h25);        eOp[3]  = 4'b0001; eIn2[3]  = 32'hA5;       eRd[3]  = 5'd11; eFlg[3]  = 3'b100;
        instr[4]  = rtype(5'd1, 5'd2, 5'd12, 6'h2A);        eOp[4]  = 4'b0111; eIn2[4]  = 32'hA5;       eRd[4]  = 5'd12; eFlg[4]  = 3'b100;
        instr[5]  = itype(6'h08, 5'd1, 5'd13, 16'hFFFC);    eOp[5]  = 4'b0010; eIn2[5]  = 32'hFFFFFFFC; eRd[5]  = 5'd13; eFlg[5]  = 3'b100;
        instr[6]  = itype(6'h0A, 5'd1, 5'd14, 16'h8001);    eOp[6]  = 4'b0111; eIn2[6]  = 32'hFFFF8001; eRd[6]  = 5'd14; eFlg[6]  = 3'b100;
        instr[7]  = itype(6'h0C, 5'd1, 5'd15, 16'hFFF0);    eOp[7]  = 4'b0000; eIn2[7]  = 32'h0000FFF0; eRd[7]  = 5'd15; eFlg[7]  = 3'b100;
        instr[8]  = itype(6'h0D, 5'd1, 5'd16, 16'h8000);    eOp[8]  = 4'b0001; eIn2[8]  = 32'h00008000; eRd[8]  = 5'd16; eFlg[8]  = 3'b100;
        instr[9]  = itype(6'h23, 5'd1, 5'd17, 16'h0004);    eOp[9]  = 4'b0010; eIn2[9]  = 32'h4;        eRd[9]  = 5'd17; eFlg[9]  = 3'b110;
        instr[10] = itype(6'h2B, 5'd1, 5'd2, 16'h0008);     eOp[10] = 4'b0010; eIn2[10] = 32'h8;        eRd[10] = 5'd2;  eFlg[10] = 3'b001;
        instr[11] = itype(6'h04, 5'd1, 5'd0, 16'h0010);     eOp[11] = 4'b0110; eIn2[11] = 32'h0;        eRd[11] = 5'd0;  eFlg[11] = 3'b000;
        instr[12] = rtype(5'd0, 5'd2, 5'd18, 6'h20);        eOp[12] = 4'b0010; eIn2[12] = 32'hA5;       eRd[12] = 5'd18; eFlg[12] = 3'b100;
        for (int i = 0; i < 13; i++) begin
            eIn1[i] = (i == 12) ? 32'h0 : 32'h80000010;
            eSt[i]  = (i == 11) ? 32'h0 : 32'hA5;
        end
        idle();
        id_rs1_data = 32'h80000010; id_rs2_data = 32'hA5;
        id_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            id_instr = instr[i];
            #1;
            nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL b2b_ready%0d: got %b expected 1", i, id_ready); else nPass++;
            tick();
            nChecks++;
            if ({alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd, alu_wr_en, alu_mem_rd, alu_mem_wr, alu_store_data}
                !== {1'b1, eOp[i], eIn1[i], eIn2[i], eRd[i], eFlg[i], eSt[i]})
                $display("[TB] FAIL b2b_row%0d: got v=%b op=%b in1=%h in2=%h rd=%0d flg=%b st=%h expected v=1 op=%b in1=%h in2=%h rd=%0d flg=%b st=%h",
                         i, alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd, {alu_wr_en, alu_mem_rd, alu_mem_wr}, alu_store_data,
                         eOp[i], eIn1[i], eIn2[i], eRd[i], eFlg[i], eSt[i]);
            else nPass++;
        end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        idle();
        id_valid = 1'b1;
        id_instr = itype(6'h23, 5'd1, 5'd5, 16'h0004);
        id_rs1_data = 32'h100; id_rs2_data = 32'h2;
        #1;
        tick();
        id_instr = rtype(5'd5, 5'd2, 5'd6, 6'h20);
        #1;
        nChecks++; if ({alu_valid, alu_mem_rd} !== 2'b11) $display("[TB] FAIL lu_load_in_idex: got %b expected 11", {alu_valid, alu_mem_rd}); else nPass++;
        nChecks++; if (id_ready !== 1'b0) $display("[TB] FAIL lu_stall: got %b expected 0", id_ready); else nPass++;
        tick();
        nChecks++; if (alu_valid !== 1'b0) $display("[TB] FAIL lu_bubble: got %b expected 0", alu_valid); else nPass++;
`ifdef ALU_ISSUE_FORWARD_EN
        memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h55;
        #1;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL lu_release: got %b expected 1", id_ready); else nPass++;
        tick();
        nChecks++;
        if ({alu_valid, alu_in1, alu_rd} !== {1'b1, 32'h55, 5'd6})
            $display("[TB] FAIL lu_issue: got v=%b in1=%h rd=%0d expected v=1 in1=55 rd=6", alu_valid, alu_in1, alu_rd);
        else nPass++;
`else
        exmem_wr_en = 1'b1; exmem_rd = 5'd5;
        #1;
        nChecks++; if (id_ready !== 1'b0) $display("[TB] FAIL lu_exmem_stall: got %b expected 0", id_ready); else nPass++;
        tick();
        exmem_wr_en = 1'b0; memwb_wr_en = 1'b1; memwb_rd = 5'd5;
        #1;
        nChecks++; if (id_ready !== 1'b0) $display("[TB] FAIL lu_memwb_stall: got %b expected 0", id_ready); else nPass++;
        tick();
        memwb_wr_en = 1'b0; id_rs1_data = 32'h77;
        #1;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL lu_release: got %b expected 1", id_ready); else nPass++;
        tick();
        nChecks++;
        if ({alu_valid, alu_in1, alu_rd} !== {1'b1, 32'h77, 5'd6})
            $display("[TB] FAIL lu_issue: got v=%b in1=%h rd=%0d expected v=1 in1=77 rd=6", alu_valid, alu_in1, alu_rd);
        else nPass++;
`endif
        idle();
        tick();
    endtask

    task automatic test_hold();
        idle();
        id_valid = 1'b1;
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        id_rs1_data = 32'd5; id_rs2_data = 32'd7;
        #1;
        tick();
        id_instr = rtype(5'd1, 5'd2, 5'd7, 6'h25);
        id_rs1_data = 32'hF0; id_rs2_data = 32'h0F;
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            nChecks++; if (id_ready !== 1'b0) $display("[TB] FAIL hold_ready%0d: got %b expected 0", c, id_ready); else nPass++;
            tick();
            nChecks++;
            if ({alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd, alu_wr_en} !== {1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b1})
                $display("[TB] FAIL hold_stable%0d: got v=%b op=%b in1=%h in2=%h rd=%0d expected ADD r3 5,7", c,
                         alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd);
            else nPass++;
        end
        ex_ready = 1'b1;
        #1;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL hold_release: got %b expected 1", id_ready); else nPass++;
        tick();
        nChecks++;
        if ({alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd} !== {1'b1, 4'b0001, 32'hF0, 32'h0F, 5'd7})
            $display("[TB] FAIL hold_next: got v=%b op=%b in1=%h in2=%h rd=%0d expected v=1 op=0001 in1=f0 in2=0f rd=7",
                     alu_valid, alu_opcode, alu_in1, alu_in2, alu_rd);
        else nPass++;
        idle();
        tick();
    endtask

    task automatic test_flush_illegal();
        idle();
        id_valid = 1'b1;
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        #1;
        tick();
        ex_ready = 1'b0; flush = 1'b1;
        id_instr = itype(6'h0D, 5'd1, 5'd9, 16'h1234);
        #1;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %b expected 1", id_ready); else nPass++;
        tick();
        flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
        nChecks++;
        if ({alu_valid, alu_wr_en, illegal} !== 3'b000)
            $display("[TB] FAIL flush_kill: got v/wr/ill=%b expected 000", {alu_valid, alu_wr_en, illegal});
        else nPass++;
        id_valid = 1'b1; flush = 1'b1;
        id_instr = 32'hFC00_0000;
        #1;
        tick();
        flush = 1'b0;
        nChecks++; if (illegal !== 1'b0) $display("[TB] FAIL flush_no_illegal: got %b expected 0", illegal); else nPass++;
        id_instr = itype(6'h3F, 5'd1, 5'd2, 16'h0);
        #1;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL ill_consumed: got %b expected 1", id_ready); else nPass++;
        tick();
        id_valid = 1'b0;
        nChecks++;
        if ({illegal, alu_valid, alu_wr_en} !== 3'b100)
            $display("[TB] FAIL ill_pulse: got ill/v/wr=%b expected 100", {illegal, alu_valid, alu_wr_en});
        else nPass++;
        tick();
        nChecks++; if (illegal !== 1'b0) $display("[TB] FAIL ill_one_cycle: got %b expected 0", illegal); else nPass++;
        id_valid = 1'b1;
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        #1;
        tick();
        id_valid = 1'b0;
        nChecks++;
        if ({illegal, alu_valid} !== 2'b10)
            $display("[TB] FAIL ill_bad_func: got ill/v=%b expected 10", {illegal, alu_valid});
        else nPass++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        id_valid = 1'b1;
        id_instr = itype(6'h23, 5'd1, 5'd5, 16'h0004);
        id_rs1_data = 32'h300; id_rs2_data = 32'h4;
        #1;
        tick();
        id_instr = rtype(5'd5, 5'd2, 5'd6, 6'h20);
        ex_ready = 1'b0;
        #1;
        nChecks++; if (id_ready !== 1'b0) $display("[TB] FAIL rms_stalled: got %b expected 0", id_ready); else nPass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        nChecks++; if (alu_valid !== 1'b0) $display("[TB] FAIL rms_cleared: got %b expected 0", alu_valid); else nPass++;
        nChecks++; if (id_ready !== 1'b1) $display("[TB] FAIL rms_ready: got %b expected 1", id_ready); else nPass++;
        tick();
        id_valid = 1'b0;
        nChecks++;
        if ({alu_valid, alu_in1, alu_in2, alu_rd} !== {1'b1, 32'h300, 32'h4, 5'd6})
            $display("[TB] FAIL rms_issue: got v=%b in1=%h in2=%h rd=%0d expected v=1 in1=300 in2=4 rd=6",
                     alu_valid, alu_in1, alu_in2, alu_rd);
        else nPass++;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_back_to_back();
        test_load_use();
        test_hold();
        test_flush_illegal();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
